// File: rtl/short_line_xfer_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : g15_xfer_pkg
// Description : Shared types and constants for the short-line transfer
//               controller. It holds the controller state encoding, the
//               destination line codes and the recirculation length.
// Revision    : 1.0 - initial release
// ============================================================================
package g15_xfer_pkg;

   // One recirculation of a short line is 4 words of 29 bit times.
   localparam int LINE_BITS = 116;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_XFER  = 2'd2,
      ST_FIN   = 2'd3
   } xfer_state_e;

   typedef enum logic [1:0] {
      DEST_M20 = 2'd0,
      DEST_M21 = 2'd1,
      DEST_M22 = 2'd2,
      DEST_ILL = 2'd3
   } dest_e;

endpackage
`default_nettype wire

// File: rtl/short_line_xfer_ctl_if.sv
`default_nettype none
// ============================================================================
// Interface   : short_line_xfer_ctl_if
// Description : Request/grant channel between one requester and the
//               short-line transfer controller.
//   req  : transfer request, level
//   dest : destination line (M20/M21/M22, 3 = illegal)
//   blk  : 1 = whole line, 0 = single word at wadr
//   wadr : word address for single-word transfers
//   gnt  : grant, level, held until done
//   done : one-cycle completion pulse
//   modport master = requester side, slave = controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface short_line_xfer_ctl_if;
   import g15_xfer_pkg::*;

   logic       req;
   dest_e      dest;
   logic       blk;
   logic [1:0] wadr;
   logic       gnt;
   logic       done;

   modport master (output req, output dest, output blk, output wadr,
                   input  gnt, input  done);
   modport slave  (input  req, input  dest, input  blk, input  wadr,
                   output gnt, output done);
endinterface
`default_nettype wire

// File: rtl/short_line_timer.sv
`default_nettype none
// ============================================================================
// Module      : short_line_timer
// Description : Bit-time / word-time counters for the short-line
//               recirculation, with drum-origin reload.
//   clk, rst   : clock (one bit time per cycle), async active-high reset
//   origin     : drum origin; next cycle is bit 0, word 0
//   bit_time   : current bit time, 0..WORD_BITS-1
//   word_time  : current word time, 0..WORDS-1
//   next_bit   : bit time of the next cycle (after any reload)
//   next_word  : word time of the next cycle (after any reload)
//   t0         : bit_time == 0
//   mismatch   : origin seen where the free-running count disagrees
// Revision    : 1.0 - initial release
// ============================================================================
module short_line_timer #(
   parameter int WORD_BITS = 29,
   parameter int WORDS     = 4,
   parameter int BIT_W     = $clog2(WORD_BITS),
   parameter int WORD_W    = $clog2(WORDS)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              origin,
   output logic [BIT_W-1:0]       bit_time,
   output logic [WORD_W-1:0]      word_time,
   output logic [BIT_W-1:0]       next_bit,
   output logic [WORD_W-1:0]      next_word,
   output logic                   t0,
   output logic                   mismatch
);

   logic last_bit;
   logic last_word;

   assign last_bit  = (bit_time  == BIT_W'(WORD_BITS - 1));
   assign last_word = (word_time == WORD_W'(WORDS - 1));
   assign t0        = (bit_time == '0);

   // An origin that lands where the count would wrap to 0/0 anyway agrees
   // with the drum and is harmless; anywhere else the count had slipped.
   assign mismatch  = origin && !(last_bit && last_word);

   always_comb begin
      next_bit  = last_bit ? '0 : bit_time + BIT_W'(1);
      next_word = word_time;
      if (last_bit) begin
         next_word = last_word ? '0 : word_time + WORD_W'(1);
      end
      if (origin) begin
         next_bit  = '0;
         next_word = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_time  <= '0;
         word_time <= '0;
      end else begin
         bit_time  <= next_bit;
         word_time <= next_word;
      end
   end

endmodule
`default_nettype wire

// File: rtl/short_line_xfer_ctl.sv
`default_nettype none
// ============================================================================
// Module      : short_line_xfer_ctl
// Description : Transfer sequencer and fixed-priority arbiter for the
//               4-word short lines M20/M21/M22. Requester A (command unit)
//               has priority over B (I/O). The granted transfer drives the
//               gate d5 and one destination select du/dv/dw over exactly
//               the requested word window.
//   clk, rst    : clock, async active-high reset
//   origin      : drum origin pulse
//   port_a/b    : requester channels (slave side)
//   err         : pulse on illegal destination or aborted transfer
//   busy        : controller not idle
//   bit_time    : bit-time counter 0..28
//   word_time   : word-time counter 0..3
//   t0          : bit_time == 0
//   d5          : transfer gate
//   du, dv, dw  : destination selects for M20, M21, M22
// Revision    : 1.0 - initial release
// ============================================================================
module short_line_xfer_ctl
   import g15_xfer_pkg::*;
#(
   parameter int WORD_BITS = 29,
   parameter int WORDS     = 4,
   parameter int BIT_W     = $clog2(WORD_BITS),
   parameter int WORD_W    = $clog2(WORDS)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              origin,
   short_line_xfer_ctl_if.slave   port_a,
   short_line_xfer_ctl_if.slave   port_b,
   output logic                   err,
   output logic                   busy,
   output logic [BIT_W-1:0]       bit_time,
   output logic [WORD_W-1:0]      word_time,
   output logic                   t0,
   output logic                   d5,
   output logic                   du,
   output logic                   dv,
   output logic                   dw
);

   logic [BIT_W-1:0]  next_bit;
   logic [WORD_W-1:0] next_word;
   logic              mismatch;

   short_line_timer #(
      .WORD_BITS (WORD_BITS),
      .WORDS     (WORDS),
      .BIT_W     (BIT_W),
      .WORD_W    (WORD_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .origin    (origin),
      .bit_time  (bit_time),
      .word_time (word_time),
      .next_bit  (next_bit),
      .next_word (next_word),
      .t0        (t0),
      .mismatch  (mismatch)
   );

   xfer_state_e       state;
   logic              sel_b;       // 1 = B holds the grant
   dest_e             dest_r;
   logic              blk_r;
   logic [WORD_W-1:0] wadr_r;
   logic [WORD_W-1:0] words_left;  // whole words still to gate after this one
   logic              illegal_r;   // current FIN is an illegal-destination reject
   logic              abort_r;     // origin slip killed the transfer last cycle

   // Request selection: A always wins a tie.
   logic              any_req;
   dest_e             req_dest;
   logic              req_blk;
   logic [WORD_W-1:0] req_wadr;

   always_comb begin
      any_req  = port_a.req || port_b.req;
      req_dest = port_b.dest;
      req_blk  = port_b.blk;
      req_wadr = port_b.wadr;
      if (port_a.req) begin
         req_dest = port_a.dest;
         req_blk  = port_a.blk;
         req_wadr = port_a.wadr;
      end
   end

   // The gate opens on the edge into a qualifying cycle, so qualification is
   // judged on the counter values of the next cycle. A grant that lands on a
   // qualifying cycle therefore waits for the following one.
   logic start_ok;
   assign start_ok = (next_bit == '0) && (blk_r || (next_word == wadr_r));

   logic last_bit;
   assign last_bit = (bit_time == BIT_W'(WORD_BITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sel_b      <= 1'b0;
         dest_r     <= DEST_M20;
         blk_r      <= 1'b0;
         wadr_r     <= '0;
         words_left <= '0;
         illegal_r  <= 1'b0;
         abort_r    <= 1'b0;
      end else begin
         abort_r   <= 1'b0;
         illegal_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  sel_b     <= !port_a.req;
                  dest_r    <= req_dest;
                  blk_r     <= req_blk;
                  wadr_r    <= req_wadr;
                  illegal_r <= (req_dest == DEST_ILL);
                  state     <= (req_dest == DEST_ILL) ? ST_FIN : ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (mismatch) begin
                  abort_r <= 1'b1;
                  state   <= ST_IDLE;
               end else if (start_ok) begin
                  words_left <= blk_r ? WORD_W'(WORDS - 1) : '0;
                  state      <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (mismatch) begin
                  abort_r <= 1'b1;
                  state   <= ST_IDLE;
               end else if (last_bit) begin
                  if (words_left == '0) begin
                     state <= ST_FIN;
                  end else begin
                     words_left <= words_left - WORD_W'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // An illegal-destination reject shows grant, done and err together in
   // its single FIN cycle; a normal FIN has the grant already dropped.
   logic gnt_on;
   logic fin;
   assign fin    = (state == ST_FIN);
   assign gnt_on = (state == ST_ALIGN) || (state == ST_XFER) || (fin && illegal_r);

   assign port_a.gnt  = gnt_on && !sel_b;
   assign port_b.gnt  = gnt_on && sel_b;
   assign port_a.done = fin && !sel_b;
   assign port_b.done = fin && sel_b;
   assign err         = abort_r || (fin && illegal_r);
   assign busy        = (state != ST_IDLE);

   assign d5 = (state == ST_XFER);
   assign du = d5 && (dest_r == DEST_M20);
   assign dv = d5 && (dest_r == DEST_M21);
   assign dw = d5 && (dest_r == DEST_M22);

endmodule
`default_nettype wire

// File: tb/tb_short_line_xfer_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_short_line_xfer_ctl
// Description : Directed self-checking bench for short_line_xfer_ctl. The
//               drum position is tracked in the bench (pos, 0..115) and all
//               expected values are derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_short_line_xfer_ctl;
   import g15_xfer_pkg::*;

   logic       clk;
   logic       rst;
   logic       origin;
   logic       err, busy, t0, d5, du, dv, dw;
   logic [4:0] bit_time;
   logic [1:0] word_time;

   short_line_xfer_ctl_if ia ();
   short_line_xfer_ctl_if ib ();

   short_line_xfer_ctl dut (
      .clk       (clk),
      .rst       (rst),
      .origin    (origin),
      .port_a    (ia),
      .port_b    (ib),
      .err       (err),
      .busy      (busy),
      .bit_time  (bit_time),
      .word_time (word_time),
      .t0        (t0),
      .d5        (d5),
      .du        (du),
      .dv        (dv),
      .dw        (dw)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;
   int pos    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (pos %0d)", tag, got, exp, pos);
   endtask

   // Advance one clock; the bench-side drum position follows origin.
   task automatic step();
      int np;
      np = origin ? 0 : (pos + 1) % LINE_BITS;
      @(posedge clk);
      #1;
      pos = np;
   endtask

   task automatic wait_pos(input int target);
      int n;
      n = 0;
      while (pos != target && n < 2 * LINE_BITS) begin
         step();
         n++;
      end
      chk("wait_pos", pos, target);
   endtask

   // Steps ncyc cycles from the current cycle (k=0) and checks every output
   // against the expected windows, all given as cycle offsets k.
   task automatic watch(input int ncyc, input bit is_b, input int dst,
                        input int gnt_from, input int gnt_to,
                        input int d5_from, input int d5_len,
                        input int done_at, input int err_at);
      for (int k = 1; k <= ncyc; k++) begin
         logic e_d5, e_gnt;
         step();
         e_d5  = (k >= d5_from) && (k < d5_from + d5_len);
         e_gnt = (k >= gnt_from) && (k <= gnt_to);
         chk("d5",     d5,      e_d5);
         chk("du",     du,      e_d5 && dst == 0);
         chk("dv",     dv,      e_d5 && dst == 1);
         chk("dw",     dw,      e_d5 && dst == 2);
         chk("gnt_a",  ia.gnt,  e_gnt && !is_b);
         chk("gnt_b",  ib.gnt,  e_gnt && is_b);
         chk("done_a", ia.done, (k == done_at) && !is_b);
         chk("done_b", ib.done, (k == done_at) && is_b);
         chk("err",    err,     k == err_at);
         chk("busy",   busy,    (k >= gnt_from) && (k <= done_at));
         if (k == gnt_from) begin
            if (is_b) ib.req = 1'b0;
            else      ia.req = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; origin = 1'b0;
      ia.req = 1'b0; ia.dest = DEST_M20; ia.blk = 1'b0; ia.wadr = 2'd0;
      ib.req = 1'b0; ib.dest = DEST_M20; ib.blk = 1'b0; ib.wadr = 2'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bit", bit_time, 0);
      chk("rst_word", word_time, 0);
      chk("rst_t0", t0, 1);
      chk("rst_d5", d5, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_gnt", {ia.gnt, ib.gnt, ia.done, ib.done}, 0);
      rst = 1'b0;
      pos = 0;

      // Origin mid-count while idle: reload, no error
      wait_pos(5);
      origin = 1'b1;
      step();
      origin = 1'b0;
      chk("reload_bit", bit_time, 0);
      chk("reload_word", word_time, 0);
      chk("reload_err", err, 0);

      // Two full lines with an agreeing origin every 116 cycles
      for (int i = 0; i < 2 * LINE_BITS; i++) begin
         chk("cnt_bit", bit_time, pos % 29);
         chk("cnt_word", word_time, pos / 29);
         chk("cnt_t0", t0, (pos % 29) == 0);
         chk("cnt_err", err, 0);
         origin = (pos == LINE_BITS - 1);
         step();
      end
      origin = 1'b0;

      // A: M21 single word at WADR=2, requested at word 0 bit 5
      wait_pos(5);
      ia.req = 1'b1; ia.dest = DEST_M21; ia.blk = 1'b0; ia.wadr = 2'd2;
      watch(83, 1'b0, 1, 1, 81, 53, 29, 82, -1);
      chk("a_done_bit", pos, 88);

      // B: M22 whole line, wraps word 3 -> 0
      ib.req = 1'b1; ib.dest = DEST_M22; ib.blk = 1'b1; ib.wadr = 2'd0;
      watch(145, 1'b1, 2, 1, 143, 28, 116, 144, -1);

      // A and B together: A (M20 word 1) first, then B (M21 word 3)
      chk("tie_pos", pos, 1);
      ia.req = 1'b1; ia.dest = DEST_M20; ia.blk = 1'b0; ia.wadr = 2'd1;
      ib.req = 1'b1; ib.dest = DEST_M21; ib.blk = 1'b0; ib.wadr = 2'd3;
      watch(57, 1'b0, 0, 1, 56, 28, 29, 57, -1);
      watch(59, 1'b1, 1, 2, 57, 29, 29, 58, -1);

      // Illegal destination: one-cycle grant with done and err
      ia.req = 1'b1; ia.dest = DEST_ILL; ia.blk = 1'b0; ia.wadr = 2'd0;
      watch(2, 1'b0, 3, 1, 1, 0, 0, 1, 1);

      // Disagreeing origin mid-transfer at word 1 bit 10 aborts
      chk("abort_pos", pos, 3);
      ia.req = 1'b1; ia.dest = DEST_M20; ia.blk = 1'b0; ia.wadr = 2'd1;
      step();
      chk("abort_gnt", ia.gnt, 1);
      ia.req = 1'b0;
      wait_pos(39);
      chk("abort_d5_pre", {d5, du}, 2'b11);
      origin = 1'b1;
      step();
      origin = 1'b0;
      chk("abort_d5", {d5, du, dv, dw}, 0);
      chk("abort_err", err, 1);
      chk("abort_gnt_drop", ia.gnt, 0);
      chk("abort_done", ia.done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_bit", bit_time, 0);
      chk("abort_word", word_time, 0);
      step();
      chk("abort_err_end", err, 0);
      chk("abort_done_end", ia.done, 0);

      // Async reset during a block transfer clears everything at once
      ib.req = 1'b1; ib.dest = DEST_M21; ib.blk = 1'b1; ib.wadr = 2'd0;
      step();
      chk("ar_gnt", ib.gnt, 1);
      ib.req = 1'b0;
      wait_pos(35);
      chk("ar_d5_pre", {d5, dv}, 2'b11);
      #2 rst = 1'b1;
      #1;
      chk("ar_d5", {d5, du, dv, dw}, 0);
      chk("ar_gnt_drop", {ia.gnt, ib.gnt}, 0);
      chk("ar_done", {ia.done, ib.done, err}, 0);
      chk("ar_busy", busy, 0);
      chk("ar_cnt", {bit_time, word_time}, 0);
      chk("ar_t0", t0, 1);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
